// File: rtl/irq_source_arbiter.sv
// irq_source_arbiter
// Shares the single user-interrupt channel of the USB host interface among
// up to 16 interrupt sources. Request edges are captured as pending events,
// one eligible source is selected, and the interrupt unit's status-byte read
// is answered with the code 8'h10 | sel. The served source gets a one-cycle
// ack pulse once the host reports completion of a user interrupt.
// Optional feature: define IRQ_ROUND_ROBIN_EN for round-robin selection
// (default build uses fixed lowest-index priority).
module irq_source_arbiter #(
  parameter int N_SRC       = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_req,
  input  logic [N_SRC-1:0] irq_mask,
  output logic [N_SRC-1:0] irq_ack,
  output logic [N_SRC-1:0] irq_pending,
  output logic             interrupt,
  input  logic             n_read,
  output logic             n_wait,
  output logic [7:0]       data,
  input  logic             user_interrupt,
  input  logic             interrupt_ok
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ASSERT,
    ST_WAIT,
    ST_READY,
    ST_ACK,
    ST_GAP
  } state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [N_SRC-1:0]   r_irqReqPrev;
  logic [N_SRC-1:0]   r_pending;
  logic [3:0]         r_sel;
  logic [3:0]         w_nextSel;
  logic [3:0]         r_wcnt;
  logic [3:0]         w_nextWcnt;
  logic [N_SRC-1:0]   w_cand;
  logic [N_SRC-1:0]   w_selOneHot;
  logic [3:0]         w_pickLow;
  logic [3:0]         w_pick;
  logic               w_busy;
  logic               r_interrupt;
  logic               r_nWait;
  logic [7:0]         r_data;
  logic [N_SRC-1:0]   r_irqAck;

  assign w_cand      = r_pending & irq_mask;
  assign irq_pending = r_pending;
  assign interrupt   = r_interrupt;
  assign n_wait      = r_nWait;
  assign data        = r_data;
  assign irq_ack     = r_irqAck;

  // Decode the frozen selection index into a one-hot source vector.
  always_comb begin
    w_selOneHot = '0;
    for (int i = 0; i < N_SRC; i++) begin
      w_selOneHot[i] = (r_sel == 4'(i));
    end
  end

  // Lowest-index eligible source; also the wrap-around fallback for round-robin.
  always_comb begin
    w_pickLow = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_cand[i]) w_pickLow = 4'(i);
    end
  end

`ifdef IRQ_ROUND_ROBIN_EN
  logic [3:0] r_lastSel;
  logic [3:0] w_pickHigh;
  logic       w_foundHigh;

  // Round-robin: prefer the lowest eligible index above the last served one.
  always_comb begin
    w_pickHigh  = '0;
    w_foundHigh = 1'b0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_cand[i] && (4'(i) > r_lastSel)) begin
        w_pickHigh  = 4'(i);
        w_foundHigh = 1'b1;
      end
    end
    w_pick = w_foundHigh ? w_pickHigh : w_pickLow;
  end

  // Remember the served source; resetting to the top index makes 0 searched first.
  always_ff @(posedge clk) begin
    if (reset) r_lastSel <= 4'(N_SRC - 1);
    else if (r_state == ST_ACK) r_lastSel <= r_sel;
  end
`else
  // Fixed priority: lowest eligible index wins.
  always_comb begin
    w_pick = w_pickLow;
  end
`endif

  // Next-state, wait-counter and selection logic for the service handshake.
  always_comb begin
    w_nextState = r_state;
    w_nextWcnt  = r_wcnt;
    w_nextSel   = r_sel;
    case (r_state)
      ST_IDLE: begin
        if (|w_cand) begin
          w_nextState = ST_ASSERT;
          w_nextSel   = w_pick;
        end
      end
      ST_ASSERT: begin
        if (!n_read) begin
          if (WAIT_CYCLES > 0) begin
            w_nextState = ST_WAIT;
            w_nextWcnt  = 4'(WAIT_CYCLES);
          end else begin
            w_nextState = ST_READY;
          end
        end
      end
      ST_WAIT: begin
        if (r_wcnt == 4'd0) w_nextState = ST_READY;
        else w_nextWcnt = r_wcnt - 4'd1;
      end
      ST_READY: begin
        if (interrupt_ok && user_interrupt) w_nextState = ST_ACK;
      end
      ST_ACK:  w_nextState = ST_GAP;
      ST_GAP:  w_nextState = ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
    w_busy = (w_nextState == ST_ASSERT) || (w_nextState == ST_WAIT) ||
             (w_nextState == ST_READY);
  end

  // State, selection and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_nextState;
      r_sel   <= w_nextSel;
      r_wcnt  <= w_nextWcnt;
    end
  end

  // Edge capture; a new edge on the source being acked wins over its clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_irqReqPrev <= irq_req;
      r_pending    <= '0;
    end else begin
      r_irqReqPrev <= irq_req;
      r_pending    <= (r_pending & ~((r_state == ST_ACK) ? w_selOneHot : '0)) |
                      (irq_req & ~r_irqReqPrev);
    end
  end

  // Registered outputs decoded from the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_interrupt <= 1'b0;
      r_nWait     <= 1'b1;
      r_data      <= 8'h00;
      r_irqAck    <= '0;
    end else begin
      r_interrupt <= w_busy;
      r_nWait     <= !(((w_nextState == ST_ASSERT) || (w_nextState == ST_WAIT)) &&
                       (WAIT_CYCLES > 0));
      r_data      <= w_busy ? {4'h1, w_nextSel} : 8'h00;
      r_irqAck    <= (w_nextState == ST_ACK) ? w_selOneHot : '0;
    end
  end

endmodule

// File: tb/tb_irq_source_arbiter.sv
// tb_irq_source_arbiter
// Directed self-checking bench for irq_source_arbiter with N_SRC=8 and
// WAIT_CYCLES=2. Expectations for the selection order follow
// IRQ_ROUND_ROBIN_EN when it is defined for the build.
module tb_irq_source_arbiter;

  logic       clk;
  logic       reset;
  logic [7:0] irq_req;
  logic [7:0] irq_mask;
  logic [7:0] irq_ack;
  logic [7:0] irq_pending;
  logic       interrupt;
  logic       n_read;
  logic       n_wait;
  logic [7:0] data;
  logic       user_interrupt;
  logic       interrupt_ok;

  int checkCount;
  int passCount;
  int failCount;

  irq_source_arbiter #(
    .N_SRC       (8),
    .WAIT_CYCLES (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .irq_req        (irq_req),
    .irq_mask       (irq_mask),
    .irq_ack        (irq_ack),
    .irq_pending    (irq_pending),
    .interrupt      (interrupt),
    .n_read         (n_read),
    .n_wait         (n_wait),
    .data           (data),
    .user_interrupt (user_interrupt),
    .interrupt_ok   (interrupt_ok)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic applyStimulus;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Runs one service from just after ASSERT entry back to IDLE entry.
  task automatic doService(input logic [7:0] expData, input logic [7:0] expAck,
                           input logic [7:0] reqAck, input logic [7:0] expPendAfter);
    n_read = 1'b0;
    applyStimulus();
    checkOutput("waitNwait0", 32'(n_wait), 32'd0);
    checkOutput("waitInt", 32'(interrupt), 32'd1);
    n_read = 1'b1;
    applyStimulus();
    checkOutput("waitNwait1", 32'(n_wait), 32'd0);
    applyStimulus();
    checkOutput("waitNwait2", 32'(n_wait), 32'd0);
    applyStimulus();
    checkOutput("readyNwait", 32'(n_wait), 32'd1);
    checkOutput("readyData", 32'(data), 32'(expData));
    checkOutput("readyInt", 32'(interrupt), 32'd1);
    interrupt_ok   = 1'b1;
    user_interrupt = 1'b0;
    applyStimulus();
    checkOutput("strayAck", 32'(irq_ack), 32'd0);
    checkOutput("strayInt", 32'(interrupt), 32'd1);
    checkOutput("strayData", 32'(data), 32'(expData));
    user_interrupt = 1'b1;
    applyStimulus();
    checkOutput("ackInt", 32'(interrupt), 32'd0);
    checkOutput("ackPulse", 32'(irq_ack), 32'(expAck));
    interrupt_ok   = 1'b0;
    user_interrupt = 1'b0;
    irq_req        = reqAck;
    applyStimulus();
    checkOutput("gapAck", 32'(irq_ack), 32'd0);
    checkOutput("gapInt", 32'(interrupt), 32'd0);
    checkOutput("gapData", 32'(data), 32'd0);
    checkOutput("gapPending", 32'(irq_pending), 32'(expPendAfter));
    irq_req = 8'h00;
    applyStimulus();
    checkOutput("idleInt", 32'(interrupt), 32'd0);
  endtask

  // Directed sequence of scenarios.
  initial begin
    checkCount     = 0;
    passCount      = 0;
    failCount      = 0;
    reset          = 1'b1;
    irq_req        = 8'h00;
    irq_mask       = 8'hFF;
    n_read         = 1'b1;
    user_interrupt = 1'b0;
    interrupt_ok   = 1'b0;
    applyStimulus();
    applyStimulus();
    checkOutput("rstInt", 32'(interrupt), 32'd0);
    checkOutput("rstNwait", 32'(n_wait), 32'd1);
    checkOutput("rstData", 32'(data), 32'd0);
    checkOutput("rstAck", 32'(irq_ack), 32'd0);
    checkOutput("rstPending", 32'(irq_pending), 32'd0);
    reset = 1'b0;
    applyStimulus();
    checkOutput("postRstInt", 32'(interrupt), 32'd0);

    // Single source 3.
    irq_req = 8'h08;
    applyStimulus();
    checkOutput("s3Pending", 32'(irq_pending), 32'h08);
    checkOutput("s3IntEarly", 32'(interrupt), 32'd0);
    irq_req = 8'h00;
    applyStimulus();
    checkOutput("s3Int", 32'(interrupt), 32'd1);
    checkOutput("s3Data", 32'(data), 32'h13);
    checkOutput("s3Nwait", 32'(n_wait), 32'd0);
    applyStimulus();
    checkOutput("s3Hold", 32'(interrupt), 32'd1);
    doService(8'h13, 8'h08, 8'h00, 8'h00);

    // Simultaneous edges on 1 and 5.
    irq_req = 8'h22;
    applyStimulus();
    checkOutput("simPending", 32'(irq_pending), 32'h22);
    irq_req = 8'h00;
    applyStimulus();
`ifdef IRQ_ROUND_ROBIN_EN
    checkOutput("simFirst", 32'(data), 32'h15);
    doService(8'h15, 8'h20, 8'h00, 8'h02);
    applyStimulus();
    checkOutput("simSecond", 32'(data), 32'h11);
    doService(8'h11, 8'h02, 8'h00, 8'h00);
`else
    checkOutput("simFirst", 32'(data), 32'h11);
    doService(8'h11, 8'h02, 8'h00, 8'h20);
    applyStimulus();
    checkOutput("simSecond", 32'(data), 32'h15);
    doService(8'h15, 8'h20, 8'h00, 8'h00);
`endif

    // Masked source 2.
    irq_mask = 8'hFB;
    irq_req  = 8'h04;
    applyStimulus();
    checkOutput("maskPending", 32'(irq_pending), 32'h04);
    irq_req = 8'h00;
    applyStimulus();
    checkOutput("maskInt0", 32'(interrupt), 32'd0);
    applyStimulus();
    checkOutput("maskInt1", 32'(interrupt), 32'd0);
    checkOutput("maskPendHold", 32'(irq_pending), 32'h04);
    irq_mask = 8'hFF;
    applyStimulus();
    checkOutput("unmaskInt", 32'(interrupt), 32'd1);
    checkOutput("unmaskData", 32'(data), 32'h12);
    doService(8'h12, 8'h04, 8'h00, 8'h00);

    // Re-request of source 4 during its ACK cycle.
    irq_req = 8'h10;
    applyStimulus();
    irq_req = 8'h00;
    applyStimulus();
    checkOutput("rrqData", 32'(data), 32'h14);
    doService(8'h14, 8'h10, 8'h10, 8'h10);
    applyStimulus();
    checkOutput("rrqAgainInt", 32'(interrupt), 32'd1);
    checkOutput("rrqAgainData", 32'(data), 32'h14);
    doService(8'h14, 8'h10, 8'h00, 8'h00);

    // Sources 0 and 1 with re-requests.
    irq_req = 8'h03;
    applyStimulus();
    checkOutput("prioPending", 32'(irq_pending), 32'h03);
    irq_req = 8'h00;
    applyStimulus();
    checkOutput("prio1", 32'(data), 32'h10);
    doService(8'h10, 8'h01, 8'h01, 8'h03);
    applyStimulus();
`ifdef IRQ_ROUND_ROBIN_EN
    checkOutput("prio2", 32'(data), 32'h11);
    doService(8'h11, 8'h02, 8'h02, 8'h03);
    applyStimulus();
    checkOutput("prio3", 32'(data), 32'h10);
    doService(8'h10, 8'h01, 8'h00, 8'h02);
    applyStimulus();
    checkOutput("prio4", 32'(data), 32'h11);
    doService(8'h11, 8'h02, 8'h00, 8'h00);
`else
    checkOutput("prio2", 32'(data), 32'h10);
    doService(8'h10, 8'h01, 8'h00, 8'h02);
    applyStimulus();
    checkOutput("prio3", 32'(data), 32'h11);
    doService(8'h11, 8'h02, 8'h00, 8'h00);
`endif

    // Reset while in WAIT discards everything.
    irq_req = 8'hC0;
    applyStimulus();
    irq_req = 8'h00;
    applyStimulus();
    checkOutput("rwData", 32'(data), 32'h16);
    n_read = 1'b0;
    applyStimulus();
    checkOutput("rwNwait", 32'(n_wait), 32'd0);
    n_read = 1'b1;
    reset  = 1'b1;
    applyStimulus();
    checkOutput("rwInt", 32'(interrupt), 32'd0);
    checkOutput("rwNwaitRst", 32'(n_wait), 32'd1);
    checkOutput("rwPending", 32'(irq_pending), 32'd0);
    checkOutput("rwData0", 32'(data), 32'd0);
    reset = 1'b0;
    applyStimulus();
    checkOutput("rwAck", 32'(irq_ack), 32'd0);
    applyStimulus();
    checkOutput("rwIdleInt", 32'(interrupt), 32'd0);
    checkOutput("rwIdlePend", 32'(irq_pending), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/irq_source_arbiter.md
# irq_source_arbiter

Shares the single user-interrupt channel of the USB host interface among up to 16 on-board interrupt sources. It captures request edges, selects one pending source, and raises `interrupt` toward the interrupt unit. It answers the unit's status-byte read cycle (`n_read`/`n_wait`/`data`) with a per-source code, then acknowledges the served source once the host has finished with the interrupt.

## Interface
Parameters:
- `N_SRC`, 8: number of request sources, 1..16.
- `WAIT_CYCLES`, 2: `n_wait`-low cycles inserted after `n_read` falls, 0..15.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `irq_req` in N_SRC: source requests; each rising edge is one event.
- `irq_mask` in N_SRC: 1 = source eligible for selection.
- `irq_ack` out N_SRC: one-cycle pulse to the source just served.
- `irq_pending` out N_SRC: captured, not yet served events.
- `interrupt` out 1: request to the interrupt unit; level.
- `n_read` in 1: status-byte read strobe from the interrupt unit; active-low.
- `n_wait` out 1: low = status byte not ready.
- `data` out 8: status byte.
- `user_interrupt` in 1: interrupt unit is servicing a user interrupt.
- `interrupt_ok` in 1: host has completed the interrupt.

## Operation
- Edge capture:
  - `irq_req_r` registers `irq_req`.
  - `pending[i]` is set when `irq_req[i] & ~irq_req_r[i]`.
  - `pending[i]` is cleared in ACK for the selected index only.
  - If set and clear land on the same cycle, set wins.
- Masked sources still capture events; they are never selected while masked.
- Selection: fixed priority, lowest index among `pending & irq_mask` (see Configuration). The index is latched into `sel` on IDLE→ASSERT and is frozen until IDLE.
- Status code: `data = 8'h10 | sel` (0x10..0x1F; never 0x01/0x02). `data` is 8'h00 in IDLE and GAP.
- State machine:
  - IDLE: if `|(pending & irq_mask)`, go to ASSERT.
  - ASSERT: `interrupt`=1. If `n_read`=0, go to WAIT and load `wcnt`=`WAIT_CYCLES`.
  - WAIT: `interrupt`=1. Decrement `wcnt` each cycle. When `wcnt`=0, go to READY.
  - READY: `interrupt`=1, `n_wait`=1, `data` valid. If `interrupt_ok & user_interrupt`, go to ACK.
  - ACK: `interrupt`=0, `irq_ack[sel]`=1, clear `pending[sel]`. Unconditionally go to GAP.
  - GAP: `interrupt`=0 for one cycle, so the unit sees a fresh rising edge. Go to IDLE.
- `n_wait` is 0 in ASSERT and WAIT when `WAIT_CYCLES`>0, and 1 otherwise. With `WAIT_CYCLES`=0, ASSERT goes directly to READY on `n_read`=0, and `n_wait` stays 1 throughout.
- `interrupt_ok` without `user_interrupt` (header/trailer service) is ignored in every state.
- `irq_mask` changes affect only the next selection.

## Timing
- All outputs are registered.
- Reset values: `interrupt`=0, `n_wait`=1, `data`=8'h00, `irq_ack`=0, `irq_pending`=0, state IDLE.
- Request latency: `irq_req` rises at edge k → `pending` set at k+1 → `interrupt`=1 at k+2, if IDLE.
- `n_read` sampled low at edge m → `n_wait`=1 and `data` valid at m+`WAIT_CYCLES`+1.
- `data` is stable from ASSERT entry through READY.
- Completion latency: `interrupt_ok & user_interrupt` at edge c → `interrupt`=0 and `irq_ack` pulse at c+1 → GAP at c+2 → earliest next `interrupt`=1 at c+4.
- Reset mid-operation: next cycle is IDLE with all pending events discarded; no `irq_ack` is issued.

## Configuration
- `IRQ_ROUND_ROBIN_EN`:
  - Defined: round-robin selection. The search starts at `last_sel+1` modulo `N_SRC`. `last_sel` updates in ACK and resets to `N_SRC-1`, so index 0 is searched first after reset.
  - Undefined: fixed lowest-index priority; no `last_sel` register.

## Test plan
- Single source: pulse `irq_req[3]`; model the unit's read with `WAIT_CYCLES`=2 → `interrupt` high 2 cycles after the edge; `n_wait` low 2 cycles after `n_read` falls, then high with `data`=0x13. After `interrupt_ok & user_interrupt` → one `irq_ack[3]` pulse and `interrupt` low for ≥2 cycles.
- Simultaneous edges on sources 1 and 5 → served in order 1, 5 with `data` 0x11 then 0x15; `irq_pending` = 0x22 → 0x20 → 0x00.
- Masked source: `irq_mask[2]`=0 and `irq_req[2]` rises → `irq_pending[2]`=1 and `interrupt` stays 0. Set the mask bit → served with `data`=0x12.
- Re-request during service: `irq_req[4]` re-rises in the ACK cycle for source 4 → `pending[4]` remains 1 and is served a second time.
- Stray completion: `interrupt_ok`=1 with `user_interrupt`=0 in READY → no ACK and state unchanged. Assert `reset` in WAIT → `interrupt`=0, `n_wait`=1, `irq_pending`=0 next cycle.
- `IRQ_ROUND_ROBIN_EN` defined: sources 0 and 1 re-requesting continuously → service alternates 0, 1, 0, 1. Undefined → source 0 is always served first.
